// File: rtl/hack_cpu_step.sv
// hack_cpu_step: parametrised Hack CPU core with run/pause/single-step
// control, self-loop halt detection and a saturating retired-instruction
// counter. Instruction ROM and data RAM live outside this block.
//
// Ports:
//   clock     in   single clock, rising-edge
//   reset     in   asynchronous, active-high
//   instr     in   [15:0]       instruction at ROM[pc], combinational
//   inM       in   [WIDTH-1:0]  RAM[addressM], combinational
//   run       in   level, execute while in RUN
//   step      in   pulse, execute one instruction while in PAUSE
//   outM      out  [WIDTH-1:0]  ALU result (driven every cycle)
//   writeM    out  RAM write strobe, RAM samples outM at the rising edge
//   addressM  out  [ADDR_W-1:0] low bits of A
//   pc        out  [ADDR_W-1:0] program counter
//   paused    out  state is PAUSE
//   halted    out  state is HALT
//   retired   out  [CNT_W-1:0]  instructions executed since reset
//
// Build option: define HACK_HALT_DETECT_EN to stop in HALT on a taken jump
// to the jump instruction's own address. Without it HALT is unreachable and
// halted is tied low.
//
// state  | meaning
// RUN    | executes one instruction per cycle while run=1
// PAUSE  | frozen; a step pulse executes one instruction
// HALT   | self-loop detected; frozen until reset

module hack_cpu_step #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic [WIDTH-1:0]  inM,
  input  logic              run,
  input  logic              step,
  output logic [WIDTH-1:0]  outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc,
  output logic              paused,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {S_RUN, S_PAUSE, S_HALT} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_reg, d_reg;
  logic [ADDR_W-1:0]  pc_reg;
  logic [CNT_W-1:0]   retired_reg;

  logic               is_c;
  logic [WIDTH-1:0]   x0, x1, x2, y0, y1, y2, fx, alu_out;
  logic               zr, ng, taken, exec, halt_hit;

  // ALU: x = D, y = A or M, standard zx/nx/zy/ny/f/no chain
  always_comb begin
    is_c    = instr[15];
    x0      = d_reg;
    y0      = instr[12] ? inM : a_reg;
    x1      = instr[11] ? '0 : x0;
    x2      = instr[10] ? ~x1 : x1;
    y1      = instr[9]  ? '0 : y0;
    y2      = instr[8]  ? ~y1 : y1;
    fx      = instr[7]  ? (x2 + y2) : (x2 & y2);
    alu_out = instr[6]  ? ~fx : fx;
    zr      = (alu_out == '0);
    ng      = alu_out[WIDTH-1];
    taken   = is_c & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~zr & ~ng));
    exec    = ((state == S_RUN) & run) | ((state == S_PAUSE) & step);
  end

  // Self-loop compares the pre-update A against the current pc
`ifdef HACK_HALT_DETECT_EN
  assign halt_hit = exec & taken & (a_reg[ADDR_W-1:0] == pc_reg);
`else
  assign halt_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN: begin
        if (halt_hit)  state_nx = S_HALT;
        else if (!run) state_nx = S_PAUSE;
      end
      S_PAUSE: begin
        if (halt_hit) state_nx = S_HALT;
        else if (run) state_nx = S_RUN;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RUN;
    endcase
  end

  always_comb begin
    paused = (state == S_PAUSE);
`ifdef HACK_HALT_DETECT_EN
    halted = (state == S_HALT);
`else
    halted = 1'b0;
`endif
    // reset gating keeps a mid-instruction reset from writing RAM
    writeM = exec & is_c & instr[3] & ~reset;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_reg       <= '0;
      d_reg       <= '0;
      pc_reg      <= '0;
      retired_reg <= '0;
    end else if (exec) begin
      if (is_c) begin
        if (instr[5]) a_reg <= alu_out;
        if (instr[4]) d_reg <= alu_out;
        pc_reg <= taken ? a_reg[ADDR_W-1:0] : pc_reg + ADDR_W'(1);
      end else begin
        a_reg  <= {{(WIDTH-15){1'b0}}, instr[14:0]};
        pc_reg <= pc_reg + ADDR_W'(1);
      end
      if (retired_reg != {CNT_W{1'b1}}) retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign outM     = alu_out;
  assign addressM = a_reg[ADDR_W-1:0];
  assign pc       = pc_reg;
  assign retired  = retired_reg;

endmodule

// File: tb/tb_hack_cpu_step.sv
module tb_hack_cpu_step;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run   = 1'b1;
  logic step  = 1'b0;

  always #5 clock = ~clock;

  logic [15:0] rom   [0:32767];
  logic [15:0] ram16 [0:32767];
  logic [15:0] mram  [0:32767];

  // 16-bit core under main test
  logic [15:0] instr16, out16, inM16;
  logic        wr16, paused16, halted16;
  logic [14:0] addr16, pc16;
  logic [31:0] ret16;
  assign instr16 = rom[pc16];
  assign inM16   = ram16[addr16];

  hack_cpu_step #(.WIDTH(16), .ADDR_W(15), .CNT_W(32)) dut16 (
    .clock(clock), .reset(reset), .instr(instr16), .inM(inM16), .run(run), .step(step),
    .outM(out16), .writeM(wr16), .addressM(addr16), .pc(pc16),
    .paused(paused16), .halted(halted16), .retired(ret16));

  // 32-bit core for the sign-boundary check
  logic [15:0] instr32;
  logic [31:0] out32, ret32;
  logic        wr32, paused32, halted32;
  logic [14:0] addr32, pc32;
  assign instr32 = rom[pc32];

  hack_cpu_step #(.WIDTH(32), .ADDR_W(15), .CNT_W(32)) dut32 (
    .clock(clock), .reset(reset), .instr(instr32), .inM(32'h0), .run(run), .step(step),
    .outM(out32), .writeM(wr32), .addressM(addr32), .pc(pc32),
    .paused(paused32), .halted(halted32), .retired(ret32));

  // 3-bit counter core fed the same fetch stream, for saturation
  logic [15:0] outS;
  logic        wrS, pausedS, haltedS;
  logic [14:0] addrS, pcS;
  logic [2:0]  retS;

  hack_cpu_step #(.WIDTH(16), .ADDR_W(15), .CNT_W(3)) dutsat (
    .clock(clock), .reset(reset), .instr(instr16), .inM(inM16), .run(run), .step(step),
    .outM(outS), .writeM(wrS), .addressM(addrS), .pc(pcS),
    .paused(pausedS), .halted(haltedS), .retired(retS));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural state only, mst 0=RUN 1=PAUSE 2=HALT
  logic [15:0] mA, mD;
  logic [14:0] mpc;
  longint      mret;
  int          mst;
  logic [15:0] e_ins, e_out;
  logic [14:0] e_addr;
  logic        e_taken, e_exec, e_wr;

  task automatic model_reset();
    mA = 0; mD = 0; mpc = 0; mret = 0; mst = 0;
  endtask

  task automatic model_eval();
    logic [15:0] ins, x, y, o;
    ins = rom[mpc];
    x = mD;
    y = ins[12] ? mram[mA[14:0]] : mA;
    if (ins[11]) x = 16'h0;
    if (ins[10]) x = ~x;
    if (ins[9])  y = 16'h0;
    if (ins[8])  y = ~y;
    o = ins[7] ? x + y : x & y;
    if (ins[6]) o = ~o;
    e_ins   = ins;
    e_out   = o;
    e_taken = ins[15] && ((ins[2] && o[15]) || (ins[1] && o == 0) || (ins[0] && o != 0 && !o[15]));
    e_exec  = (mst == 0 && run) || (mst == 1 && step);
    e_wr    = e_exec && ins[15] && ins[3];
    e_addr  = mA[14:0];
  endtask

  task automatic model_commit();
    logic halt;
    halt = 1'b0;
    if (e_exec) begin
`ifdef HACK_HALT_DETECT_EN
      halt = e_taken && (mA[14:0] == mpc);
`endif
      if (e_wr) mram[e_addr] = e_out;
      if (!e_ins[15]) begin
        mA  = {1'b0, e_ins[14:0]};
        mpc = mpc + 15'd1;
      end else begin
        mpc = e_taken ? mA[14:0] : mpc + 15'd1;
        if (e_ins[5]) mA = e_out;
        if (e_ins[4]) mD = e_out;
      end
      mret++;
    end
    if (mst != 2) begin
      if (e_exec && halt)        mst = 2;
      else if (mst == 0 && !run) mst = 1;
      else if (mst == 1 && run)  mst = 0;
    end
  endtask

  // One clock: the bench RAM takes the DUT's write, the model advances.
  task automatic model_tick();
    logic        w;
    logic [14:0] a;
    logic [15:0] d;
    model_eval();
    #1;
    w = wr16; a = addr16; d = out16;
    @(posedge clock);
    if (w) ram16[a] = d;
    model_commit();
    @(negedge clock);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
  endtask

  task automatic apply_reset(input logic run_v);
    @(negedge clock);
    reset = 1'b1; step = 1'b0; run = run_v;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 16'hE308;                 // M=D
    reset = 1'b1; run = 1'b1; step = 1'b0;
    @(negedge clock); #1;
    n_tests++; if (pc16 !== 15'd0)  begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc16); end
    n_tests++; if (ret16 !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", ret16); end
    n_tests++; if (wr16 !== 1'b0)   begin n_fail++; $display("FAIL reset_writeM: got %0b expected 0", wr16); end
    n_tests++; if ({paused16, halted16} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {paused16, halted16}); end
    n_tests++; if (out16 !== 16'd0) begin n_fail++; $display("FAIL reset_outM: got %0h expected 0", out16); end
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++; if (wr16 !== 1'b1)   begin n_fail++; $display("FAIL release_writeM: got %0b expected 1", wr16); end
  endtask

  task automatic test_arith();
    clear_rom();
    rom[0] = 16'h0002; rom[1] = 16'hEC10; rom[2] = 16'h0003;
    rom[3] = 16'hE090; rom[4] = 16'h0000; rom[5] = 16'hE308;
    ram16[0] = 16'hFFFF; mram[0] = 16'hFFFF;
    apply_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (wr16 !== 1'b0) begin n_fail++; $display("FAIL arith_early_writeM: cycle %0d got %0b expected 0", i, wr16); end
      model_tick();
    end
    #1;
    n_tests++; if ({wr16, out16, addr16} !== {1'b1, 16'd5, 15'd0}) begin
      n_fail++; $display("FAIL arith_store: got wr=%0b out=%0d addr=%0d expected wr=1 out=5 addr=0", wr16, out16, addr16); end
    model_tick();
    n_tests++; if (ram16[0] !== 16'd5) begin n_fail++; $display("FAIL arith_ram: got %0d expected 5", ram16[0]); end
    n_tests++; if (ret16 !== 32'd6)    begin n_fail++; $display("FAIL arith_retired: got %0d expected 6", ret16); end
  endtask

  task automatic test_pause_step();
    clear_rom();
    rom[0] = 16'h0000; rom[1] = 16'hEC10;
    for (int i = 2; i < 8; i++) rom[i] = 16'hE7C8;   // M=D+1
    apply_reset(1'b1);
    model_tick(); model_tick();
    run = 1'b0; #1;
    model_tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++; if ({paused16, pc16, wr16} !== {1'b1, 15'd2, 1'b0}) begin
        n_fail++; $display("FAIL pause_hold: cycle %0d got paused=%0b pc=%0d wr=%0b expected 1 2 0", i, paused16, pc16, wr16); end
      model_tick();
    end
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1; #1;
      n_tests++; if (wr16 !== 1'b1) begin n_fail++; $display("FAIL step_writeM: step %0d got %0b expected 1", k, wr16); end
      model_tick();
      step = 1'b0; #1;
      n_tests++; if ({pc16, wr16, paused16} !== {15'(2 + k), 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL step_pc: step %0d got pc=%0d wr=%0b paused=%0b expected %0d 0 1", k, pc16, wr16, paused16, 2 + k); end
      model_tick();
    end
    n_tests++; if (ret16 !== 32'd5)    begin n_fail++; $display("FAIL step_retired: got %0d expected 5", ret16); end
    n_tests++; if (ram16[0] !== 16'd1) begin n_fail++; $display("FAIL step_ram: got %0d expected 1", ram16[0]); end
    step = 1'b1; run = 1'b1; #1;
    model_tick();
    step = 1'b0; #1;
    n_tests++; if ({paused16, pc16, ret16} !== {1'b0, 15'd6, 32'd6}) begin
      n_fail++; $display("FAIL step_run_resume: got paused=%0b pc=%0d ret=%0d expected 0 6 6", paused16, pc16, ret16); end
  endtask

  task automatic test_width();
    clear_rom();
    rom[0] = 16'h7FFF; rom[1] = 16'hEC10; rom[2] = 16'h000A;
    rom[3] = 16'hE7D0; rom[4] = 16'hE301;                // D;JGT
    apply_reset(1'b1);
    for (int i = 0; i < 4; i++) model_tick();
    #1;
    n_tests++; if (out16 !== 16'h8000) begin n_fail++; $display("FAIL width16_D: got %0h expected 8000", out16); end
    n_tests++; if (out32 !== 32'h8000) begin n_fail++; $display("FAIL width32_D: got %0h expected 8000", out32); end
    model_tick();
    n_tests++; if (pc16 !== 15'd5)  begin n_fail++; $display("FAIL width16_jgt: got pc %0d expected 5", pc16); end
    n_tests++; if (pc32 !== 15'd10) begin n_fail++; $display("FAIL width32_jgt: got pc %0d expected 10", pc32); end
    n_tests++; if ({ret32, addr32, wr32, paused32, halted32} !== {32'd5, 15'd10, 3'b000}) begin
      n_fail++; $display("FAIL width32_state: got ret=%0d addr=%0d wr=%0b p=%0b h=%0b expected 5 10 0 0 0", ret32, addr32, wr32, paused32, halted32); end
  endtask

  task automatic test_halt();
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = 16'(i + 1);
    rom[5] = 16'h0006; rom[6] = 16'hEA87;                // @6 ; 0;JMP
    apply_reset(1'b1);
    for (int i = 0; i < 6; i++) model_tick();
    n_tests++; if (halted16 !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %0b expected 0", halted16); end
    model_tick();
    n_tests++; if ({pc16, ret16} !== {15'd6, 32'd7}) begin n_fail++; $display("FAIL halt_retire: got pc=%0d ret=%0d expected 6 7", pc16, ret16); end
`ifdef HACK_HALT_DETECT_EN
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom); step = 1'($urandom); #1;
      n_tests++; if ({halted16, pc16, ret16, wr16} !== {1'b1, 15'd6, 32'd7, 1'b0}) begin
        n_fail++; $display("FAIL halt_frozen: cycle %0d got h=%0b pc=%0d ret=%0d wr=%0b expected 1 6 7 0", i, halted16, pc16, ret16, wr16); end
      model_tick();
    end
    run = 1'b1; step = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      n_tests++; if ({halted16, pc16, ret16} !== {1'b0, 15'd6, 32'(7 + i)}) begin
        n_fail++; $display("FAIL spin: cycle %0d got h=%0b pc=%0d ret=%0d expected 0 6 %0d", i, halted16, pc16, ret16, 7 + i); end
      model_tick();
    end
`endif
    n_tests++; if (retS !== 3'd7) begin n_fail++; $display("FAIL retired_saturate: got %0d expected 7", retS); end
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hE308;
    apply_reset(1'b1);
    for (int i = 0; i < 3; i++) model_tick();
    #1;
    n_tests++; if ({wr16, addr16} !== {1'b1, 15'd7}) begin n_fail++; $display("FAIL mid_pre: got wr=%0b addr=%0d expected 1 7", wr16, addr16); end
    #1 reset = 1'b1;
    #1;
    n_tests++; if ({pc16, ret16, addr16, wr16} !== {15'd0, 32'd0, 15'd0, 1'b0}) begin
      n_fail++; $display("FAIL mid_clear: got pc=%0d ret=%0d addr=%0d wr=%0b expected 0 0 0 0", pc16, ret16, addr16, wr16); end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    model_tick();
    n_tests++; if ({pc16, ret16, addr16} !== {15'd1, 32'd1, 15'd5}) begin
      n_fail++; $display("FAIL mid_restart: got pc=%0d ret=%0d addr=%0d expected 1 1 5", pc16, ret16, addr16); end
  endtask

  task automatic test_random();
    int diffs;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32768; i++) begin
        rom[i]   = 16'($urandom);
        ram16[i] = 16'($urandom);
        mram[i]  = ram16[i];
      end
      apply_reset(1'b1);
      for (int c = 0; c < 150; c++) begin
        run  = ($urandom_range(0, 5) != 0);
        step = ($urandom_range(0, 2) == 0);
        #1;
        model_eval();
        n_tests++; if ({pc16, ret16, paused16, halted16} !== {mpc, mret[31:0], (mst == 1), (mst == 2)}) begin
          n_fail++; $display("FAIL rand_state: run %0d cyc %0d got pc=%0d ret=%0d p=%0b h=%0b expected %0d %0d %0b %0b",
            r, c, pc16, ret16, paused16, halted16, mpc, mret, mst == 1, mst == 2); end
        n_tests++; if ({out16, wr16, addr16} !== {e_out, e_wr, e_addr}) begin
          n_fail++; $display("FAIL rand_bus: run %0d cyc %0d got out=%0h wr=%0b addr=%0h expected %0h %0b %0h",
            r, c, out16, wr16, addr16, e_out, e_wr, e_addr); end
        n_tests++; if ({pcS, wrS, outS, addrS, pausedS, haltedS, retS} !==
                       {mpc, e_wr, e_out, e_addr, (mst == 1), (mst == 2), (mret > 7 ? 3'd7 : 3'(mret))}) begin
          n_fail++; $display("FAIL rand_sat_core: run %0d cyc %0d got pc=%0d ret=%0d expected %0d %0d", r, c, pcS, retS, mpc, mret); end
        model_tick();
      end
      diffs = 0;
      for (int i = 0; i < 32768; i++) if (ram16[i] !== mram[i]) diffs++;
      n_tests++; if (diffs != 0) begin n_fail++; $display("FAIL rand_ram: run %0d got %0d differing words expected 0", r, diffs); end
    end
    step = 1'b0; run = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin ram16[i] = 16'h0; mram[i] = 16'h0; end
    model_reset();
    test_reset();
    test_arith();
    test_pause_step();
    test_width();
    test_halt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hack_cpu_step.md
# hack_cpu_step

Parametrised Hack CPU core with run/pause/single-step control, self-loop halt detection and a retired-instruction counter. It replaces the fixed 16-bit CPU inside the Hack computer. Instruction ROM and data RAM stay outside the block. The core runs programs such as `sum.hack` and can be frozen and stepped from a bench or a debug front-end.

## Interface
Parameters:
- WIDTH, 16, datapath width of A, D, ALU, inM/outM; must be >= 16
- ADDR_W, 15, width of pc and addressM; must be <= 15
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- instr  in  16  Hack instruction at ROM[pc], valid combinationally in the same cycle
- inM  in  WIDTH  RAM[addressM], valid combinationally in the same cycle
- run  in  1  level; core executes while in RUN and run=1
- step  in  1  one-cycle pulse; executes one instruction while PAUSE
- outM  out  WIDTH  ALU result
- writeM  out  1  RAM write strobe; RAM samples outM at the rising edge
- addressM  out  ADDR_W  A[ADDR_W-1:0]
- pc  out  ADDR_W  current program counter
- paused  out  1  state == PAUSE
- halted  out  1  state == HALT
- retired  out  CNT_W  instructions executed since reset; saturates

## Operation
- States are RUN, PAUSE and HALT. Reset state is RUN.
- exec = (RUN & run) | (PAUSE & step). exec is combinational.
- State transitions:
  - RUN with run=0 goes to PAUSE.
  - PAUSE with run=1 goes to RUN. If step and run are both 1 in PAUSE, exec=1 for that cycle and the next state is RUN.
  - HALT exits only on reset. run and step are ignored in HALT.
  - step is ignored in RUN.
- A-instruction (instr[15]=0): A <= zero-extended instr[14:0]. pc <= pc+1.
- C-instruction fields:
  - a = instr[12]
  - zx, nx, zy, ny, f, no = instr[11:6]
  - dA, dD, dM = instr[5:3]
  - j1, j2, j3 = instr[2:0]
- ALU:
  - x = D; y = a ? inM : A.
  - Standard Hack zx/nx/zy/ny/f/no semantics, computed in WIDTH bits, modulo 2^WIDTH.
  - zr = (out == 0). ng = out[WIDTH-1].
- Jump: taken = (j1&ng) | (j2&zr) | (j3&~zr&~ng).
- Register updates:
  - If taken, pc <= old A[ADDR_W-1:0]. Otherwise pc <= pc+1. pc wraps modulo 2^ADDR_W.
  - A <= out if dA; D <= out if dD.
  - The jump target always uses the A value from before this instruction's update.
- writeM = exec & instr[15] & dM. writeM is forced to 0 when exec=0.
- outM and addressM are driven every cycle regardless of exec.
- When exec=0, A, D, pc and retired hold their values.
- retired increments by 1 on every exec cycle and saturates at 2^CNT_W-1.

## Timing
- Single-cycle execution: each exec cycle retires one instruction at the rising edge.
- Fetch-to-retire latency is 0 cycles beyond that edge.
- Reset values:
  - A = D = pc = 0, retired = 0, state = RUN.
  - paused = 0, halted = 0.
  - writeM = 0 while reset is asserted.
  - outM = ALU(instr) combinationally.
- Reset asserted mid-instruction: state clears immediately and no RAM write occurs, because writeM is gated by reset.
- After reset deasserts with run=1, the first instruction (ROM[0]) retires on the first rising edge.
- The halting instruction itself retires: retired is incremented and pc reloads its own address. halted=1 from the next cycle.

## Configuration
- HACK_HALT_DETECT_EN defined:
  - An exec cycle with a C-instruction whose jump is taken and old A[ADDR_W-1:0] == pc moves the state to HALT.
  - This matches the `@END; 0;JMP` end-of-program idiom.
- Undefined:
  - The HALT state is unreachable and halted is tied to 0.
  - A self-loop spins forever and retired keeps counting.

## Test plan
- Reset mid-run: execute 3 instructions, then pulse reset asynchronously between edges. A, D, pc and retired read 0 immediately, with no writeM pulse. Execution restarts at ROM[0].
- Arithmetic: program @2, D=A, @3, D=D+A, @0, M=D with run=1 (WIDTH=16). writeM=1 on the 6th exec cycle with outM=5 and addressM=0. RAM[0]=5 and retired=6.
- Pause/step:
  - Drop run after 2 instructions. paused=1 and pc holds at 2 for 10 cycles.
  - Three single-cycle step pulses: pc becomes 3, 4, 5 and retired becomes 5.
  - writeM is high only in step cycles.
- Width: load D=0x7FFF then D=D+1; D;JGT.
  - WIDTH=32: jump taken, because 0x8000 is positive.
  - WIDTH=16: not taken, because ng=1.
- Halt, macro defined: ROM[5]=@6, ROM[6]=0;JMP. After ROM[6] retires, halted=1, pc=6 and retired=7, all frozen for the next 20 cycles. run and step have no effect.
- Halt, macro undefined: same program. halted stays 0, pc stays 6, and retired increments every cycle.
